// File: rtl/cdf_pkg.sv
// Shared definitions for the CDF accumulator and the downstream divider stage.
// Holds the default pass geometry, the histogram address width and the
// accumulator FSM state encoding.
package cdf_pkg;

  // Default number of histogram bins per pass.
  localparam int unsigned CdfNumBins = 256;
  // Default width of bin counts and of the cumulative sum.
  localparam int unsigned CdfDataW   = 32;
  // Width of the histogram memory address bus.
  localparam int unsigned CdfAddrW   = 8;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWaitData,
    StEmit,
    StWaitDiv,
    StDone
  } cdf_state_e;

endpackage

// File: rtl/cdf_sat_add.sv
// Cumulative-sum adder.
// Build option: define CDF_SATURATE_EN to clamp on overflow; otherwise the sum
// wraps modulo 2^DATA_W and ovf is tied low.
// Ports:
//   a   - current running sum
//   b   - bin count to add
//   sum - result (clamped to all-ones on overflow when saturating)
//   ovf - high when the true result exceeded 2^DATA_W-1 (saturating build only)
module cdf_sat_add
  import cdf_pkg::*;
#(
  parameter int unsigned DATA_W = CdfDataW
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              ovf
);

`ifdef CDF_SATURATE_EN
  logic [DATA_W:0] full;

  // One extra bit captures the carry that marks an out-of-range result.
  assign full = {1'b0, a} + {1'b0, b};
  assign ovf  = full[DATA_W];
  assign sum  = full[DATA_W] ? {DATA_W{1'b1}} : full[DATA_W-1:0];
`else
  assign sum = a + b;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/cdf_accumulator.sv
// Walks a histogram memory bin by bin, producing a running cumulative sum
// (CDF) one value at a time for a downstream divider, with handshake back
// pressure from the divider.
// Build option: CDF_SATURATE_EN selects a saturating sum with a sticky
// overflow flag (see cdf_sat_add); without it the sum wraps.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous reset, active low
//   enable     - global run; low freezes all state and masks strobes
//   start      - one-cycle pulse that begins a pass (ignored while busy)
//   hist_rd_en - histogram read strobe
//   hist_addr  - histogram bin address
//   hist_data  - bin count, valid the cycle after hist_rd_en
//   cdf_out    - running cumulative sum
//   cdf_valid  - one-cycle pulse qualifying cdf_out
//   div_ready  - divider has consumed the last cdf_out
//   cdf_min    - first nonzero cdf_out of the current pass
//   busy       - pass in progress
//   done       - one-cycle end-of-pass pulse
//   overflow   - sticky sum-overflow flag
module cdf_accumulator
  import cdf_pkg::*;
#(
  parameter int unsigned NUM_BINS = CdfNumBins,
  parameter int unsigned DATA_W   = CdfDataW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                start,
  output logic                hist_rd_en,
  output logic [CdfAddrW-1:0] hist_addr,
  input  logic [DATA_W-1:0]   hist_data,
  output logic [DATA_W-1:0]   cdf_out,
  output logic                cdf_valid,
  input  logic                div_ready,
  output logic [DATA_W-1:0]   cdf_min,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  // One spare index bit so a run past the last bin stays observable.
  localparam int unsigned     IdxW    = CdfAddrW + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BINS - 1);

  cdf_state_e        state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] cdf_q, cdf_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic              min_found_q, min_found_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W-1:0] add_sum;
  logic              add_ovf;

  cdf_sat_add #(
    .DATA_W (DATA_W)
  ) u_add (
    .a   (cdf_q),
    .b   (hist_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cdf_d       = cdf_q;
    min_d       = min_q;
    min_found_d = min_found_q;
    ovf_d       = ovf_q;
    hist_rd_en  = 1'b0;
    cdf_valid   = 1'b0;
    done        = 1'b0;

    // With enable low nothing advances, so a masked READ or EMIT strobe is
    // simply re-issued from the held state once enable returns.
    if (enable) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d     = StRead;
            idx_d       = '0;
            cdf_d       = '0;
            min_d       = '0;
            min_found_d = 1'b0;
            ovf_d       = 1'b0;
          end
        end
        StRead: begin
          hist_rd_en = 1'b1;
          state_d    = StWaitData;
        end
        StWaitData: begin
          cdf_d   = add_sum;
          ovf_d   = ovf_q | add_ovf;
          state_d = StEmit;
        end
        StEmit: begin
          cdf_valid = 1'b1;
          if (!min_found_q && (cdf_q != '0)) begin
            min_d       = cdf_q;
            min_found_d = 1'b1;
          end
          state_d = StWaitDiv;
        end
        StWaitDiv: begin
          if (div_ready) begin
            if (idx_q == LastIdx) begin
              state_d = StDone;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = StRead;
            end
          end
        end
        StDone: begin
          done    = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cdf_q       <= '0;
      min_q       <= '0;
      min_found_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cdf_q       <= cdf_d;
      min_q       <= min_d;
      min_found_q <= min_found_d;
      ovf_q       <= ovf_d;
    end
  end

  assign hist_addr = idx_q[CdfAddrW-1:0];
  assign cdf_out   = cdf_q;
  assign cdf_min   = min_q;
  assign busy      = (state_q != StIdle);
  assign overflow  = ovf_q;

  // The FSM must leave for DONE at the last bin; an index beyond it is a bug.
  idx_in_range_a: assert property (@(posedge clk) disable iff (!reset) idx_q <= LastIdx);

endmodule

// File: tb/tb_cdf_accumulator.sv
// Randomized self-checking bench for cdf_accumulator against a plain
// arithmetic model of a histogram-to-CDF pass.
module tb_cdf_accumulator;

  localparam int unsigned NB = 256;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          start = 1'b0;
  logic          div_ready = 1'b1;
  logic          hist_rd_en;
  logic [7:0]    hist_addr;
  logic [DW-1:0] hist_data = '0;
  logic [DW-1:0] cdf_out;
  logic          cdf_valid;
  logic [DW-1:0] cdf_min;
  logic          busy;
  logic          done;
  logic          overflow;

  always #5 clk = ~clk;

  cdf_accumulator #(
    .NUM_BINS (NB),
    .DATA_W   (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .hist_rd_en (hist_rd_en),
    .hist_addr  (hist_addr),
    .hist_data  (hist_data),
    .cdf_out    (cdf_out),
    .cdf_valid  (cdf_valid),
    .div_ready  (div_ready),
    .cdf_min    (cdf_min),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  // Histogram memory: registered read, output held until the next read.
  logic [DW-1:0] mem [NB];
  always @(posedge clk) if (hist_rd_en) hist_data <= mem[hist_addr];

  // Monitor: logs every strobe away from the active edge.
  int unsigned   cyc = 0;
  logic [DW-1:0] vq[$];
  int unsigned   vt[$];
  logic [7:0]    aq[$];
  int unsigned   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (cdf_valid) begin
      vq.push_back(cdf_out);
      vt.push_back(cyc);
    end
    if (hist_rd_en) aq.push_back(hist_addr);
    if (done) done_cnt <= done_cnt + 1;
  end

  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: running sum over the whole histogram.
  logic [DW-1:0] exp_sum [NB];
  logic [DW-1:0] exp_min;
  logic          exp_ovf;

  function automatic void build_model();
    longint unsigned acc = 0;
    bit found = 0;
    exp_min = '0;
    exp_ovf = 1'b0;
    for (int i = 0; i < NB; i++) begin
      acc = acc + longint'(mem[i]);
`ifdef CDF_SATURATE_EN
      if (acc > 64'hFFFF_FFFF) begin
        acc = 64'hFFFF_FFFF;
        exp_ovf = 1'b1;
      end
`else
      acc = acc & 64'hFFFF_FFFF;
`endif
      exp_sum[i] = acc[DW-1:0];
      if (!found && acc != 0) begin
        found = 1;
        exp_min = acc[DW-1:0];
      end
    end
  endfunction

  bit rand_en = 0;
  bit rand_dr = 0;
  int unsigned start_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_en) enable = ($urandom_range(0, 3) != 0);
    if (rand_dr) div_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rd_en"}, 64'(hist_rd_en), 64'd0);
    check_eq({tag, "_addr"}, 64'(hist_addr), 64'd0);
    check_eq({tag, "_cdf"}, 64'(cdf_out), 64'd0);
    check_eq({tag, "_valid"}, 64'(cdf_valid), 64'd0);
    check_eq({tag, "_min"}, 64'(cdf_min), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_ovf"}, 64'(overflow), 64'd0);
  endtask

  task automatic start_pass(input string tag, output int unsigned vbase,
                            output int unsigned abase, output int unsigned d0);
    bit idle = 0;
    for (int i = 0; i < 2000 && !idle; i++) begin
      if (!busy) idle = 1;
      else tick();
    end
    check_eq({tag, "_idle_before_start"}, 64'(idle), 64'd1);
    vbase = vq.size();
    abase = aq.size();
    d0 = done_cnt;
    start = 1'b1;
    enable = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned d0);
    bit fin = 0;
    for (int i = 0; i < 20000 && !fin; i++) begin
      if (done_cnt != d0) fin = 1;
      else tick();
    end
    check_eq({tag, "_done_seen"}, 64'(fin), 64'd1);
    rand_en = 0;
    rand_dr = 0;
    enable = 1'b1;
    div_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic check_pass(input string tag, input int unsigned vbase,
                            input int unsigned abase, input int unsigned d0);
    check_eq({tag, "_nvalid"}, 64'(vq.size() - vbase), 64'(NB));
    check_eq({tag, "_nread"}, 64'(aq.size() - abase), 64'(NB));
    for (int i = 0; i < NB; i++) begin
      if (vbase + i < vq.size()) check_eq({tag, "_cdf"}, 64'(vq[vbase + i]), 64'(exp_sum[i]));
      if (abase + i < aq.size()) check_eq({tag, "_addr"}, 64'(aq[abase + i]), 64'(i));
    end
    check_eq({tag, "_final_cdf"}, 64'(cdf_out), 64'(exp_sum[NB-1]));
    check_eq({tag, "_min"}, 64'(cdf_min), 64'(exp_min));
    check_eq({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    check_eq({tag, "_ndone"}, 64'(done_cnt - d0), 64'd1);
    check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  function automatic void fill_random();
    for (int i = 0; i < NB; i++) begin
      case ($urandom_range(0, 15))
        0, 1:    mem[i] = '0;
        2:       mem[i] = DW'($urandom);
        default: mem[i] = DW'($urandom_range(0, 5000));
      endcase
    end
  endfunction

  int unsigned vb, ab, d0, nv, na;
  bit hit;

  initial begin
    // Reset state, with and without clock edges.
    #1;
    check_reset_outputs("rst_noclk");
    repeat (3) tick();
    check_reset_outputs("rst_clk");
    reset = 1'b1;
    enable = 1'b1;
    tick();

    // All bins = 1, free-flowing divider.
    for (int i = 0; i < NB; i++) mem[i] = 32'd1;
    build_model();
    start_pass("ones", vb, ab, d0);
    wait_done("ones", d0);
    check_pass("ones", vb, ab, d0);
    check_eq("ones_min_is_1", 64'(cdf_min), 64'd1);
    if (vt.size() >= vb + NB) begin
      check_eq("ones_latency", 64'(vt[vb] - start_cyc), 64'd3);
      check_eq("ones_spacing", 64'(vt[vb + NB - 1] - vt[vb]), 64'((NB - 1) * 4));
    end

    // Leading zero bins then a 7.
    fill_random();
    for (int i = 0; i < 10; i++) mem[i] = '0;
    mem[10] = 32'd7;
    build_model();
    start_pass("zeros", vb, ab, d0);
    wait_done("zeros", d0);
    check_pass("zeros", vb, ab, d0);
    check_eq("zeros_min_is_7", 64'(cdf_min), 64'd7);

    // Sum overflow at bin 1.
    for (int i = 0; i < NB; i++) mem[i] = '0;
    mem[0] = 32'hFFFF_FFF0;
    mem[1] = 32'h0000_0020;
    build_model();
    start_pass("ovf", vb, ab, d0);
    wait_done("ovf", d0);
    check_pass("ovf", vb, ab, d0);
`ifdef CDF_SATURATE_EN
    check_eq("ovf_clamped", 64'(cdf_out), 64'hFFFF_FFFF);
    check_eq("ovf_flag", 64'(overflow), 64'd1);
`else
    check_eq("ovf_wrapped", 64'(cdf_out), 64'h10);
    check_eq("ovf_flag", 64'(overflow), 64'd0);
`endif

    // Divider stalls 20 cycles after the first pulse.
    fill_random();
    build_model();
    div_ready = 1'b0;
    start_pass("stall", vb, ab, d0);
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (vq.size() > vb) hit = 1;
      else tick();
    end
    check_eq("stall_first_valid", 64'(hit), 64'd1);
    nv = vq.size();
    na = aq.size();
    repeat (20) tick();
    check_eq("stall_no_valid", 64'(vq.size()), 64'(nv));
    check_eq("stall_no_read", 64'(aq.size()), 64'(na));
    div_ready = 1'b1;
    wait_done("stall", d0);
    check_pass("stall", vb, ab, d0);

    // Reset in the middle of a pass, then a clean restart.
    fill_random();
    build_model();
    start_pass("abort", vb, ab, d0);
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      if (hist_rd_en && hist_addr == 8'd100) hit = 1;
      else tick();
    end
    check_eq("abort_reached_bin100", 64'(hit), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    tick();
    tick();
    reset = 1'b1;
    nv = vq.size();
    repeat (5) tick();
    check_eq("abort_stays_idle", 64'(busy), 64'd0);
    check_eq("abort_no_valid", 64'(vq.size()), 64'(nv));
    start_pass("restart", vb, ab, d0);
    wait_done("restart", d0);
    check_pass("restart", vb, ab, d0);

    // Enable low during READ plus stray start pulses while busy.
    fill_random();
    build_model();
    start_pass("hold", vb, ab, d0);
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      if (hist_rd_en && hist_addr == 8'd5) hit = 1;
      else tick();
    end
    check_eq("hold_reached_bin5", 64'(hit), 64'd1);
    enable = 1'b0;
    na = aq.size();
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
    end
    start = 1'b0;
    check_eq("hold_no_read_while_off", 64'(aq.size()), 64'(na));
    enable = 1'b1;
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      if (hist_rd_en && hist_addr == 8'd40) hit = 1;
      else tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("hold", d0);
    check_pass("hold", vb, ab, d0);

    // Random bins with random enable and divider back pressure.
    for (int p = 0; p < 2; p++) begin
      fill_random();
      build_model();
      rand_en = 1;
      rand_dr = 1;
      start_pass("rand", vb, ab, d0);
      wait_done("rand", d0);
      check_pass("rand", vb, ab, d0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
